cache_block_fetcher: RTL and testbench

//  Miss-side refill engine under the per-basic-block direct-mapped caches: round-robin arbitration
//  of NUM_CLIENTS block requests, issue of BLOCK_WIDTH word reads to a shared in-order memory port,

---
 rtl/cache_block_fetcher.sv | 170 +++++++++++++++++
 tb/tb_cache_block_fetcher.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_block_fetcher.sv
// cache_block_fetcher
//   Refill engine that sits under the per-basic-block direct-mapped caches.
//   It picks one requesting cache round-robin and reads that cache's line
//   from a shared in-order memory port, one word at a time. When the whole
//   line has arrived, the winning cache gets a one-cycle req_ready pulse.
//   This is a read-only path with no coherence.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   req_valid      [NUM_CLIENTS]      client i wants a line
//   req_addr       [NUM_CLIENTS*OAW]  line address of client i (slice i)
//   req_ready      [NUM_CLIENTS]      one-cycle completion pulse to client i
//   line_data      [DWIDTH*BLOCK]     assembled line, word k at [k*DWIDTH+:DWIDTH]
//   mem_rd_valid   out                word read request
//   mem_rd_addr    [ADDR_IN_WIDTH]    {line address, word index}
//   mem_rd_ready   in                 memory accepts the request this cycle
//   mem_rsp_valid  in                 read data valid, returned in request order
//   mem_rsp_data   [DWIDTH]           read data
//   o_dbg_state    [1:0]              current FSM state (0 idle, 1 fill, 2 done)
//
// Handshake: a word read transfers on a cycle where mem_rd_valid && mem_rd_ready.
// Once mem_rd_valid is raised, it stays high with a stable address until the
// read is accepted. Responses have no back-pressure: every mem_rsp_valid beat
// seen during a fill is taken.
module cache_block_fetcher #(
  parameter int DWIDTH           = 4,
  parameter int BLOCK_WIDTH_BITS = 4,
  parameter int ADDR_IN_WIDTH    = 16,
  parameter int NUM_CLIENTS      = 2,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic [NUM_CLIENTS-1:0]                                   req_valid,
  input  logic [NUM_CLIENTS*(ADDR_IN_WIDTH-BLOCK_WIDTH_BITS)-1:0]  req_addr,
  output logic [NUM_CLIENTS-1:0]                                   req_ready,
  output logic [DWIDTH*(2**BLOCK_WIDTH_BITS)-1:0]                  line_data,
  output logic                                                     mem_rd_valid,
  output logic [ADDR_IN_WIDTH-1:0]                                 mem_rd_addr,
  input  logic                                                     mem_rd_ready,
  input  logic                                                     mem_rsp_valid,
  input  logic [DWIDTH-1:0]                                        mem_rsp_data,
  output logic [1:0]                                               o_dbg_state
);
  localparam int BLOCK_WIDTH    = 2**BLOCK_WIDTH_BITS;
  localparam int OUT_ADDR_WIDTH = ADDR_IN_WIDTH - BLOCK_WIDTH_BITS;
  localparam int CW             = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNTW           = BLOCK_WIDTH_BITS + 1;
  localparam logic [CNTW-1:0] C_BLOCK  = CNTW'(BLOCK_WIDTH);
  localparam logic [CNTW-1:0] C_MAX_OS = CNTW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0]   C_LAST   = CW'(NUM_CLIENTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CW-1:0]             r_rr_ptr;
  logic [CW-1:0]             r_grant;
  logic [OUT_ADDR_WIDTH-1:0] r_addr;
  logic [CNTW-1:0]           r_issue_cnt;
  logic [CNTW-1:0]           r_rsp_cnt;
  logic [DWIDTH-1:0]         r_line [BLOCK_WIDTH];

  logic                      w_any;
  logic                      w_hi_found;
  logic [CW-1:0]             w_hi_idx;
  logic [CW-1:0]             w_lo_idx;
  logic [CW-1:0]             w_grant_idx;
  logic [CNTW-1:0]           w_outstanding;
  logic                      w_issue_fire;
  logic                      w_rsp_take;
  logic [OUT_ADDR_WIDTH-1:0] w_req_addr [NUM_CLIENTS];

  for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_addr
    assign w_req_addr[c] = req_addr[c*OUT_ADDR_WIDTH +: OUT_ADDR_WIDTH];
  end

  // Round-robin pick. The lowest requester at or above the pointer wins.
  // If there is none, the lowest requester overall wins (wrap-around).
  always_comb begin
    w_any      = 1'b0;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_any    = 1'b1;
        w_lo_idx = CW'(i);
        if (CW'(i) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = CW'(i);
        end
      end
    end
    w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = '0;
    mem_rd_valid  = 1'b0;
    w_outstanding = r_issue_cnt - r_rsp_cnt;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_FILL;
      S_FILL: begin
        // Outstanding only shrinks while a request waits, so valid cannot drop
        // before acceptance.
        mem_rd_valid = (r_issue_cnt < C_BLOCK) && (w_outstanding < C_MAX_OS);
        if (r_rsp_cnt == C_BLOCK) w_next = S_DONE;
      end
      S_DONE: begin
        // A client that gave up during the fill gets no pulse; the line is dropped.
        req_ready[r_grant] = req_valid[r_grant];
        w_next             = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_rd_addr  = {r_addr, r_issue_cnt[BLOCK_WIDTH_BITS-1:0]};
  assign w_issue_fire = mem_rd_valid && mem_rd_ready;
  assign w_rsp_take   = (r_state == S_FILL) && mem_rsp_valid && (r_rsp_cnt < C_BLOCK);
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_rsp_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant     <= w_grant_idx;
            r_addr      <= w_req_addr[w_grant_idx];
            r_issue_cnt <= '0;
            r_rsp_cnt   <= '0;
          end
        end
        S_FILL: begin
          if (w_issue_fire) r_issue_cnt <= r_issue_cnt + 1'b1;
          if (w_rsp_take)   r_rsp_cnt   <= r_rsp_cnt + 1'b1;
        end
        S_DONE: r_rr_ptr <= (r_grant == C_LAST) ? '0 : r_grant + 1'b1;
        default: ;
      endcase
    end
  end

  // The line buffer changes only during a fill, so the client can still read
  // the line for a few cycles after its pulse.
  always_ff @(posedge clk) begin
    if (!rst && w_rsp_take) r_line[r_rsp_cnt[BLOCK_WIDTH_BITS-1:0]] <= mem_rsp_data;
  end

  for (genvar k = 0; k < BLOCK_WIDTH; k++) begin : g_line
    assign line_data[k*DWIDTH +: DWIDTH] = r_line[k];
  end
endmodule

// File: tb/tb_cache_block_fetcher.sv
// Bench for cache_block_fetcher. A behavioural memory answers word reads in
// order. Line contents come from a closed-form word function. The expected
// pulse order comes from a transaction-level round-robin model.
module tb_cache_block_fetcher;
  localparam int DW = 4, BWB = 4, BW = 16, AIW = 16, OAW = 12, NC = 2, MO = 4;
  localparam int LW = DW * BW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     req_valid;
  logic [NC*OAW-1:0] req_addr;
  logic [NC-1:0]     req_ready;
  logic [LW-1:0]     line_data;
  logic              mem_rd_valid;
  logic [AIW-1:0]    mem_rd_addr;
  logic              mem_rd_ready;
  logic              mem_rsp_valid;
  logic [DW-1:0]     mem_rsp_data;
  logic [1:0]        o_dbg_state;

  cache_block_fetcher #(
    .DWIDTH(DW), .BLOCK_WIDTH_BITS(BWB), .ADDR_IN_WIDTH(AIW),
    .NUM_CLIENTS(NC), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .line_data(line_data), .mem_rd_valid(mem_rd_valid),
    .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shared bench state ----------------
  int errors = 0;
  int checks = 0;
  logic [LW:0] exp_q[$];           // {client, line}
  int   rr_model;
  int   salt, lat, ready_pct, stall_cnt, spurious_cnt, rsp_delivered;
  int   last_pulse_cyc;
  logic [LW-1:0] last_pulse_line;

  // Memory content: word = (low nibble + salt * line address) mod 16.
  function automatic logic [DW-1:0] mem_word(input logic [AIW-1:0] a, input int s);
    int v;
    v = (int'(a[3:0]) + s * int'(a[AIW-1:4])) % 16;
    return DW'(v);
  endfunction

  function automatic logic [LW-1:0] exp_line(input logic [OAW-1:0] la, input int s);
    logic [LW-1:0]  l;
    logic [BWB-1:0] kk;
    l = '0;
    for (int k = 0; k < BW; k++) begin
      kk = BWB'(k);
      l[k*DW +: DW] = mem_word({la, kk}, s);
    end
    return l;
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Raise the requests in mask together. Clients that hold their requests are
  // served in round-robin order starting at the model pointer. Clients in
  // nopush give up before completion, so nothing is expected for them.
  task automatic issue(input logic [NC-1:0] mask, input logic [OAW-1:0] a0,
                       input logic [OAW-1:0] a1, input logic [NC-1:0] nopush);
    logic [NC-1:0] m;
    int c;
    req_addr  = {a1, a0};
    req_valid = req_valid | mask;
    m = mask;
    while (m != '0) begin
      for (int k = 0; k < NC; k++) begin
        c = (rr_model + k) % NC;
        if (m[c]) begin
          if (!nopush[c]) exp_q.push_back({1'(c), exp_line((c == 0) ? a0 : a1, salt)});
          m[c]     = 1'b0;
          rr_model = (c + 1) % NC;
          break;
        end
      end
    end
  endtask

  // Runs cycles until every request has been served (or dropped) and the
  // block is idle again. A client lowers its request after its pulse.
  task automatic wait_done(input int budget);
    int n;
    logic [NC-1:0] clr;
    n = 0;
    while ((req_valid != '0 || exp_q.size() != 0 || o_dbg_state != 2'd0) && n < budget) begin
      @(negedge clk);
      clr = req_ready;
      if (req_ready != '0) begin
        last_pulse_cyc  = cyc;
        last_pulse_line = line_data;
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~clr;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_done: no completion after %0d cycles, %0d lines pending", n, exp_q.size());
      req_valid = '0;
      exp_q.delete();
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  // ---------------- memory model ----------------
  int   pend_due[$];
  logic [DW-1:0] pend_data[$];
  logic hold_req, fire, rst_seen;
  logic [AIW-1:0] hold_addr, acc_addr;
  int   in_flight;

  initial begin
    mem_rd_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; hold_req = 1'b0;
    forever begin
      @(negedge clk);
      rst_seen = rst;
      fire     = 1'b0;
      if (!rst) begin
        in_flight = pend_data.size() + (mem_rsp_valid ? 1 : 0);
        if (mem_rd_valid) begin
          checks++;
          if (in_flight >= MO) begin
            errors++;
            $display("FAIL outstanding: got %0d reads in flight, limit %0d", in_flight + 1, MO);
          end
        end
        if (hold_req) begin
          checks++;
          if (!mem_rd_valid || mem_rd_addr !== hold_addr) begin
            errors++;
            $display("FAIL addr_hold: got valid=%b addr=%h expected valid=1 addr=%h",
                     mem_rd_valid, mem_rd_addr, hold_addr);
          end
        end
        fire      = mem_rd_valid && mem_rd_ready;
        acc_addr  = mem_rd_addr;
        hold_req  = mem_rd_valid && !mem_rd_ready;
        hold_addr = mem_rd_addr;
      end else begin
        hold_req = 1'b0;
      end
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      if (rst_seen) begin
        pend_data.delete();
        pend_due.delete();
      end else if (fire) begin
        pend_data.push_back(mem_word(acc_addr, salt));
        pend_due.push_back(cyc + lat - 1);
      end
      if (spurious_cnt > 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = DW'($urandom_range(0, 15));
        spurious_cnt--;
      end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = pend_data.pop_front();
        void'(pend_due.pop_front());
        rsp_delivered++;
      end
      if (stall_cnt > 0) begin
        mem_rd_ready = 1'b0;
        stall_cnt--;
      end else begin
        mem_rd_ready = ($urandom_range(0, 99) < ready_pct);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [LW:0]   e;
  logic [NC-1:0] er;
  logic [LW-1:0] hold_line;
  logic          line_hold_pending = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      line_hold_pending = 1'b0;
    end else begin
      if (line_hold_pending) begin
        checks++;
        if (line_data !== hold_line) begin
          errors++;
          $display("FAIL line_hold: got %h expected %h", line_data, hold_line);
        end
        line_hold_pending = 1'b0;
      end
      if (req_ready != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got req_ready=%b expected none", req_ready);
        end else begin
          e  = exp_q.pop_front();
          er = '0;
          er[e[LW]] = 1'b1;
          if (req_ready !== er || line_data !== e[LW-1:0]) begin
            errors++;
            $display("FAIL pulse: got ready=%b line=%h expected ready=%b line=%h",
                     req_ready, line_data, er, e[LW-1:0]);
          end
          hold_line         = e[LW-1:0];
          line_hold_pending = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int t0, n, d0;
  logic [NC-1:0]  mask;
  logic [OAW-1:0] a0, a1;
  logic [LW-1:0]  ref_line;

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0;
    salt = 0; lat = 1; ready_pct = 100; stall_cnt = 0; spurious_cnt = 0;
    rsp_delivered = 0; rr_model = 0; last_pulse_cyc = 0; last_pulse_line = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", LW'(o_dbg_state), '0);
    check("reset_req_ready", LW'(req_ready), '0);
    check("reset_rd_valid", LW'(mem_rd_valid), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single client, zero-wait memory, response one cycle later.
    t0 = cyc;
    issue(2'b01, 12'h0A5, 12'h000, 2'b00);
    wait_done(200);
    check("latency", LW'(last_pulse_cyc - t0), LW'(19));
    check("line_0a5", last_pulse_line, 64'hFEDCBA9876543210);

    // Simultaneous requests, twice.
    salt = 3;
    issue(2'b11, 12'h111, 12'h222, 2'b00);
    wait_done(400);
    issue(2'b11, 12'h333, 12'h444, 2'b00);
    wait_done(400);

    // Memory stalls mid-fill while responses take 5 cycles.
    salt = 5; lat = 5;
    issue(2'b01, 12'h5A5, 12'h000, 2'b00);
    repeat (6) @(posedge clk);
    #1 stall_cnt = 3;
    wait_done(400);

    // Client gives up during the fill; the next request is served normally.
    lat = 1;
    issue(2'b10, 12'h000, 12'h777, 2'b10);
    repeat (5) @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_done(200);
    issue(2'b01, 12'h888, 12'h000, 2'b00);
    wait_done(200);

    // Reset once seven words have been captured.
    salt = 7;
    d0 = rsp_delivered;
    issue(2'b01, 12'h999, 12'h000, 2'b01);
    n = 0;
    while (rsp_delivered - d0 < 7 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("reset_wait", LW'(n < 100), LW'(1));
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    check("midreset_state", LW'(o_dbg_state), '0);
    check("midreset_req_ready", LW'(req_ready), '0);
    check("midreset_rd_valid", LW'(mem_rd_valid), '0);
    check("midreset_rd_addr", LW'(mem_rd_addr), '0);
    rst = 1'b0; rr_model = 0;
    @(posedge clk); #1;
    issue(2'b01, 12'h123, 12'h000, 2'b00);
    wait_done(200);
    ref_line = exp_line(12'h123, salt);

    // Stray responses while idle must not disturb the line or the counters.
    spurious_cnt = 2;
    repeat (5) @(posedge clk);
    #1;
    check("spurious_line", line_data, ref_line);
    check("spurious_state", LW'(o_dbg_state), '0);
    issue(2'b10, 12'h000, 12'hABC, 2'b00);
    wait_done(200);

    // Randomized mix of clients, latencies and back-pressure.
    for (int it = 0; it < 16; it++) begin
      salt      = $urandom_range(0, 15);
      lat       = $urandom_range(1, 6);
      ready_pct = $urandom_range(40, 100);
      mask      = NC'($urandom_range(1, 3));
      a0        = OAW'($urandom);
      a1        = OAW'($urandom);
      issue(mask, a0, a1, 2'b00);
      wait_done(1500);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
